// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg : shared widths, select encodings, default times, counter states
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package traffic_pkg;

  localparam int COUNT_W = 4;

  localparam logic [1:0] INT_BASE = 2'b00;
  localparam logic [1:0] INT_EXT  = 2'b01;
  localparam logic [1:0] INT_YEL  = 2'b10;

  localparam int DEF_BASE = 6;
  localparam int DEF_EXT  = 3;
  localparam int DEF_YEL  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } cnt_state_t;

endpackage

`default_nettype wire

// File: rtl/time_param_regs.sv
// ----------------------------------------------------------------------------
// time_param_regs : base/extended/yellow time registers, edge-triggered writes
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module time_param_regs
  import traffic_pkg::*;
#(
  parameter int COUNT_W      = traffic_pkg::COUNT_W,
  parameter int BASE_DEFAULT = DEF_BASE,
  parameter int EXT_DEFAULT  = DEF_EXT,
  parameter int YEL_DEFAULT  = DEF_YEL
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               prog_sync,
  input  logic [1:0]         time_param_sel,
  input  logic [COUNT_W-1:0] time_value,
  input  logic [1:0]         interval,
  output logic [COUNT_W-1:0] param_value
);

  logic               prog_q;
  logic               prog_write;
  logic [COUNT_W-1:0] base_q;
  logic [COUNT_W-1:0] ext_q;
  logic [COUNT_W-1:0] yel_q;

  assign prog_write = prog_sync & ~prog_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prog_q <= 1'b0;
      base_q <= COUNT_W'(BASE_DEFAULT);
      ext_q  <= COUNT_W'(EXT_DEFAULT);
      yel_q  <= COUNT_W'(YEL_DEFAULT);
    end else begin
      prog_q <= prog_sync;
      // A programmed value of zero means "back to the reset default"
      if (prog_write) begin
        case (time_param_sel)
          INT_BASE: base_q <= (time_value == '0) ? COUNT_W'(BASE_DEFAULT) : time_value;
          INT_EXT:  ext_q  <= (time_value == '0) ? COUNT_W'(EXT_DEFAULT)  : time_value;
          INT_YEL:  yel_q  <= (time_value == '0) ? COUNT_W'(YEL_DEFAULT)  : time_value;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    case (interval)
      INT_EXT: param_value = ext_q;
      INT_YEL: param_value = yel_q;
      default: param_value = base_q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/interval_timer.sv
// ----------------------------------------------------------------------------
// interval_timer : programmable seconds down-counter with one-cycle expiry pulse
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module interval_timer
  import traffic_pkg::*;
#(
  parameter int COUNT_W      = traffic_pkg::COUNT_W,
  parameter int BASE_DEFAULT = DEF_BASE,
  parameter int EXT_DEFAULT  = DEF_EXT,
  parameter int YEL_DEFAULT  = DEF_YEL
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               one_hz_enable,
  input  logic               start_timer,
  input  logic [1:0]         interval,
  input  logic               prog_sync,
  input  logic [1:0]         time_param_sel,
  input  logic [COUNT_W-1:0] time_value,
  output logic               expired,
  output logic               busy,
  output logic [COUNT_W-1:0] remaining
);

  cnt_state_t         state;
  cnt_state_t         next_state;
  logic [COUNT_W-1:0] load_value;
  logic [COUNT_W-1:0] remaining_next;
  logic               expired_next;

  time_param_regs #(
    .COUNT_W      (COUNT_W),
    .BASE_DEFAULT (BASE_DEFAULT),
    .EXT_DEFAULT  (EXT_DEFAULT),
    .YEL_DEFAULT  (YEL_DEFAULT)
  ) u_params (
    .clock          (clock),
    .reset_n        (reset_n),
    .prog_sync      (prog_sync),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .interval       (interval),
    .param_value    (load_value)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      expired   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      remaining <= remaining_next;
      expired   <= expired_next;
      busy      <= (next_state == COUNT);
    end
  end

  // Start has priority over a coincident tick, even on the final second
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_timer) next_state = COUNT;
      COUNT: if (!start_timer && one_hz_enable && remaining == COUNT_W'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    remaining_next = remaining;
    expired_next   = 1'b0;
    if (start_timer) begin
      remaining_next = load_value;
    end else if (state == COUNT && one_hz_enable) begin
      remaining_next = remaining - COUNT_W'(1);
      expired_next   = (remaining == COUNT_W'(1));
    end
  end

endmodule

`default_nettype wire

// File: doc/interval_timer.md
# interval_timer

Programmable interval timer that serves the traffic-light FSM. It holds the three time parameters (base, extended, yellow) in a small register file, reprogrammable at run time through the synchronized program input. On `start_timer` it loads the parameter chosen by `interval` and counts down on the 1 Hz enable. It returns a single-cycle `expired` pulse to the FSM and sits between the FSM, the clock divider and the synchronizer block.

## Interface
- `COUNT_W`, 4, width of time parameters and down-counter (seconds, 1..15)
- `BASE_DEFAULT`, 6, reset value of base parameter (tBASE)
- `EXT_DEFAULT`, 3, reset value of extended parameter (tEXT)
- `YEL_DEFAULT`, 2, reset value of yellow parameter (tYEL)

- `clock`  in  1  system clock; the only clock in the block
- `reset_n`  in  1  reset, asynchronous, active-low
- `one_hz_enable`  in  1  single-cycle tick from the divider, one per second
- `start_timer`  in  1  FSM request: load the selected interval and (re)start counting
- `interval`  in  2  parameter select for the load: 00 base, 01 extended, 10 yellow, 11 treated as base
- `prog_sync`  in  1  synchronized program strobe (level); one write per rising edge
- `time_param_sel`  in  2  parameter to program: 00 base, 01 extended, 10 yellow, 11 ignored
- `time_value`  in  COUNT_W  value to program; 0 restores that parameter's default
- `expired`  out  1  one-cycle pulse when the count reaches zero
- `busy`  out  1  high while counting
- `remaining`  out  COUNT_W  current down-count value (seconds left)

## Operation
- Parameter registers:
  - Reset to the `*_DEFAULT` values.
  - Write on a `prog_sync` rising edge: `prog_sync`=1 while the registered previous value (`prog_q`) is 0. `prog_q` resets to 0.
  - The write stores `time_value` into `time_param_sel`; a value of 0 stores the default; `sel`=11 causes no write.
- Counter FSM states:
  - IDLE: `busy`=0. `start_timer` loads `remaining` with the selected parameter and moves to COUNT.
  - COUNT: `busy`=1. On each `one_hz_enable`, `remaining` decrements. On the tick where `remaining`==1, `remaining` becomes 0, the state returns to IDLE and `expired` is 1 for exactly one cycle.
- `start_timer` in COUNT restarts: reload from the current `interval` and stay in COUNT. No `expired` is produced for the aborted count.
- Start wins: `start_timer` together with `one_hz_enable` loads the full value and ignores the tick. This holds even when `remaining`==1, so no `expired` pulse.
- Ticks in IDLE are ignored; `remaining` holds its value (0 after expiry).
- Programming never disturbs a running count. A write to the parameter being counted takes effect on the next `start_timer`.
- Programming and starting in the same cycle: the load uses the pre-write (old) parameter value.
- Reset mid-count: asynchronous return to IDLE and defaults restored. `expired`, `busy` and `remaining` all go to 0 immediately.

## Timing
- Reset values: `expired`=0, `busy`=0, `remaining`=0, state IDLE, parameters at their defaults.
- Load latency: `start_timer` sampled at edge k gives `busy`=1 and `remaining`=N after edge k.
- Expiry: `expired` is high during the cycle following the edge that samples the Nth tick after the load. It is registered, with no combinational path from inputs.
- Program latency: a new value is visible to a load sampled one edge after the detected `prog_sync` rising edge.
- Every output is registered on the rising edge of `clock`.

## Structure
- Package `traffic_pkg` holds:
  - `COUNT_W`;
  - the interval/parameter-select encodings (`INT_BASE`=00, `INT_EXT`=01, `INT_YEL`=10);
  - the default time constants;
  - the counter state enum (IDLE, COUNT).
- Sub-module `time_param_regs` contains the three parameter registers, the `prog_sync` edge detect, the zero-restores-default rule, and a read mux on `interval` (11 maps to base).
- The top level holds the counter FSM, the down-counter and the `expired`/`busy` registers.

## Test plan
- Reset, then `start_timer` with `interval`=00, then 6 ticks spaced 10 cycles apart → `remaining` goes 6,5,…,1. After the 6th tick `remaining`=0, `busy`=0 and `expired` is high for one cycle only.
- `interval`=01 and 10 with defaults → `expired` after exactly 3 and 2 ticks. `interval`=11 → expires after 6 ticks.
- Program `sel`=10, `value`=5, holding `prog_sync` high 20 cycles, then start yellow → a single write occurs and the count expires after 5 ticks. Program `sel`=10, `value`=0 → yellow returns to 2.
- Start base, and after 3 ticks program base=9 → the current count still expires after 6 total ticks; the next base start expires after 9.
- `start_timer` coincident with a tick while `remaining`=1 → no `expired`, `remaining`=6, count continues. A restart mid-count with `interval`=10 reloads 2.
- Deassert `reset_n` mid-count (between clock edges) → outputs go to 0 at once; after release, the base parameter is 6 again, even if it was reprogrammed before.
